// File: rtl/vr_log_reader_pkg.sv
// Shared VR definitions: entry size, reader state encoding and the 32-bit size type.
package vr_log_reader_pkg;

   localparam int unsigned ENTRY_BYTES = 64;
   localparam int unsigned ENTRY_SHIFT = $clog2(ENTRY_BYTES);

   typedef logic [31:0] size_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SIZE_OUT = 2'd1,
      STREAM   = 2'd2
   } state_t;

   function automatic size_t count_to_bytes(input logic [15:0] count);
      return size_t'(count) << ENTRY_SHIFT;
   endfunction

endpackage

// File: rtl/vr_log_reader_fifo.sv
// Two-entry skid FIFO between the log RAM responses and the beat output.
module vr_log_reader_fifo #(
   parameter int WIDTH = 512
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             empty,
   output logic [1:0]       count
);

   logic [WIDTH-1:0] mem [2];
   logic             wr_ptr;
   logic             rd_ptr;
   logic             full;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == 2'd0);
   assign full    = (count == 2'd2);
   assign do_pop  = pop && !empty;
   // A push into a full FIFO is legal only when the head leaves in the same cycle.
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) wr_ptr <= ~wr_ptr;
         if (do_pop)  rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/vr_log_reader.sv
// Log reader: reports request size, then streams log entries via a 2-deep credit-limited FIFO.
//   state    | meaning
//   IDLE     | waiting for a read request (req_rdy high)
//   SIZE_OUT | presenting size_bytes until size_rdy
//   STREAM   | issuing log RAM reads and emitting entry beats until the last one
module vr_log_reader
   import vr_log_reader_pkg::*;
#(
   parameter int LOG_IDX_W = 10,
   parameter int ENTRY_W   = 512
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_val,
   input  logic [LOG_IDX_W-1:0] req_start_idx,
   input  logic [15:0]          req_count,
   output logic                 req_rdy,
   output logic                 size_val,
   output size_t                size_bytes,
   input  logic                 size_rdy,
   output logic                 log_rd_req_val,
   output logic [LOG_IDX_W-1:0] log_rd_req_addr,
   input  logic                 log_rd_req_rdy,
   input  logic                 log_rd_resp_val,
   input  logic [ENTRY_W-1:0]   log_rd_resp_data,
   output logic                 data_val,
   output logic [ENTRY_W-1:0]   data,
   output logic                 data_last,
   input  logic                 data_rdy
);

   state_t               state, state_nxt;
   logic [LOG_IDX_W-1:0] rd_addr;
   logic [15:0]          count_q;
   logic [15:0]          reads_left;
   logic [15:0]          beats_done;
   logic [1:0]           in_flight;
   size_t                size_q;

   logic                 fifo_empty;
   logic [1:0]           fifo_cnt;
   logic [ENTRY_W-1:0]   fifo_head;

   logic                 streaming;
   logic                 resp_push;
   logic                 beat_pop;
   logic                 rd_fire;
   logic                 last_beat;
   logic [2:0]           committed;

   assign streaming = (state == STREAM);
   assign resp_push = streaming && log_rd_resp_val;
   assign beat_pop  = data_val && data_rdy;
   assign rd_fire   = log_rd_req_val && log_rd_req_rdy;
   assign last_beat = ((beats_done + 16'd1) == count_q);
   // Slots promised to reads: a beat leaving this cycle frees its slot at once,
   // which keeps one read per cycle flowing while data_rdy stays high.
   assign committed = {1'b0, in_flight} + {1'b0, fifo_cnt} - {2'b00, beat_pop};

   assign size_bytes      = size_q;
   assign log_rd_req_addr = rd_addr;
   assign data            = fifo_head;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (req_val) state_nxt = SIZE_OUT;
         SIZE_OUT: if (size_rdy) state_nxt = (count_q != 16'd0) ? STREAM : IDLE;
         STREAM:   if (beat_pop && data_last) state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_comb begin
      req_rdy        = 1'b0;
      size_val       = 1'b0;
      log_rd_req_val = 1'b0;
      data_val       = 1'b0;
      data_last      = 1'b0;
      if (!rst) begin
         req_rdy        = (state == IDLE);
         size_val       = (state == SIZE_OUT);
         log_rd_req_val = streaming && (reads_left != 16'd0) && (committed < 3'd2);
         data_val       = streaming && !fifo_empty;
         data_last      = streaming && !fifo_empty && last_beat;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_addr    <= '0;
         count_q    <= 16'd0;
         reads_left <= 16'd0;
         beats_done <= 16'd0;
         in_flight  <= 2'd0;
         size_q     <= '0;
      end else if (state == IDLE && req_val) begin
         rd_addr    <= req_start_idx;
         count_q    <= req_count;
         reads_left <= req_count;
         beats_done <= 16'd0;
         in_flight  <= 2'd0;
         size_q     <= count_to_bytes(req_count);
      end else begin
         if (rd_fire) begin
            rd_addr    <= rd_addr + 1'b1;
            reads_left <= reads_left - 16'd1;
         end
         in_flight <= in_flight + {1'b0, rd_fire} - {1'b0, resp_push};
         if (beat_pop) beats_done <= beats_done + 16'd1;
      end
   end

   vr_log_reader_fifo #(
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (resp_push),
      .push_data (log_rd_resp_data),
      .pop       (beat_pop),
      .head      (fifo_head),
      .empty     (fifo_empty),
      .count     (fifo_cnt)
   );

endmodule

// File: tb/tb_vr_log_reader.sv
// Bench for vr_log_reader: table of requests checked through address/beat/size scoreboards.
module tb_vr_log_reader;

   localparam int LW = 10;
   localparam int EW = 512;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_val = 1'b0;
   logic [LW-1:0] req_start_idx = '0;
   logic [15:0]   req_count = '0;
   logic          req_rdy;
   logic          size_val;
   logic [31:0]   size_bytes;
   logic          size_rdy = 1'b1;
   logic          log_rd_req_val;
   logic [LW-1:0] log_rd_req_addr;
   logic          log_rd_req_rdy = 1'b1;
   logic          log_rd_resp_val = 1'b0;
   logic [EW-1:0] log_rd_resp_data = '0;
   logic          data_val;
   logic [EW-1:0] data;
   logic          data_last;
   logic          data_rdy = 1'b1;

   always #5 clk = ~clk;

   vr_log_reader #(.LOG_IDX_W(LW), .ENTRY_W(EW)) dut (
      .clk              (clk),
      .rst              (rst),
      .req_val          (req_val),
      .req_start_idx    (req_start_idx),
      .req_count        (req_count),
      .req_rdy          (req_rdy),
      .size_val         (size_val),
      .size_bytes       (size_bytes),
      .size_rdy         (size_rdy),
      .log_rd_req_val   (log_rd_req_val),
      .log_rd_req_addr  (log_rd_req_addr),
      .log_rd_req_rdy   (log_rd_req_rdy),
      .log_rd_resp_val  (log_rd_resp_val),
      .log_rd_resp_data (log_rd_resp_data),
      .data_val         (data_val),
      .data             (data),
      .data_last        (data_last),
      .data_rdy         (data_rdy)
   );

   typedef struct { logic [EW-1:0] data; logic last; } beat_t;
   typedef struct { int due; int addr; } rd_t;
   typedef struct { int start; int count; int lat; bit stall; logic [31:0] size; } vec_t;

   beat_t       beat_q[$];
   int          addr_q[$];
   logic [31:0] size_q[$];
   rd_t         ram_q[$];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int lat   = 1;
   bit stall = 1'b0;
   bit tog   = 1'b0;
   bit spur  = 1'b0;
   int reads_seen = 0;
   int beats_seen = 0;
   int max_out = 0;
   int first_beat_cyc = 0;
   int last_beat_cyc = 0;
   bit prev_dstall = 1'b0;
   bit prev_sstall = 1'b0;
   logic [EW-1:0] prev_data;
   logic [31:0]   prev_size;

   task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic logic [EW-1:0] entry_of(input int a);
      logic [EW-1:0] e;
      for (int i = 0; i < EW/32; i++) e[i*32 +: 32] = 32'hC0DE0000 ^ 32'(a * 37 + i);
      return e;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Log RAM model, consumer ready patterns, and sampling 1 time unit before each rising edge.
   always @(negedge clk) begin
      beat_t b;
      tog = ~tog;
      data_rdy = stall ? tog : 1'b1;
      size_rdy = stall ? ~tog : 1'b1;
      log_rd_req_rdy = 1'b1;
      log_rd_resp_val = 1'b0;
      log_rd_resp_data = '0;
      if (spur) begin
         log_rd_resp_val = 1'b1;
         log_rd_resp_data = '1;
      end else if (ram_q.size() > 0 && ram_q[0].due == cyc + 1) begin
         log_rd_resp_val = 1'b1;
         log_rd_resp_data = entry_of(ram_q[0].addr);
         void'(ram_q.pop_front());
      end
      #4;
      if (!rst) begin
         if (prev_dstall) begin
            chk("data_hold_val", data_val, 1'b1);
            chk("data_hold", data, prev_data);
         end
         if (prev_sstall) begin
            chk("size_hold_val", size_val, 1'b1);
            chk("size_hold", size_bytes, prev_size);
         end
         prev_dstall = data_val && !data_rdy;
         prev_data   = data;
         prev_sstall = size_val && !size_rdy;
         prev_size   = size_bytes;
         if (size_val && size_rdy) begin
            if (size_q.size() == 0) chk("unexpected_size", 1'b1, 1'b0);
            else chk("size_bytes", size_bytes, size_q.pop_front());
         end
         if (log_rd_req_val && log_rd_req_rdy) begin
            reads_seen++;
            if (addr_q.size() == 0) chk("unexpected_read", 1'b1, 1'b0);
            else chk("rd_addr", log_rd_req_addr, addr_q.pop_front());
            ram_q.push_back('{due: cyc + 1 + lat, addr: int'(log_rd_req_addr)});
         end
         if (data_val && data_rdy) begin
            beats_seen++;
            if (beats_seen == 1) first_beat_cyc = cyc;
            last_beat_cyc = cyc;
            if (beat_q.size() == 0) chk("unexpected_beat", 1'b1, 1'b0);
            else begin
               b = beat_q.pop_front();
               chk("beat_data", data, b.data);
               chk("beat_last", data_last, b.last);
            end
         end
         if (reads_seen - beats_seen > max_out) max_out = reads_seen - beats_seen;
      end else begin
         prev_dstall = 1'b0;
         prev_sstall = 1'b0;
      end
   end

   task automatic setup_req(input int start, input int count, input int l, input bit s,
                            input logic [31:0] sz);
      @(posedge clk);
      lat = l;
      stall = s;
      reads_seen = 0;
      beats_seen = 0;
      max_out = 0;
      for (int i = 0; i < count; i++) begin
         addr_q.push_back((start + i) % (1 << LW));
         beat_q.push_back('{data: entry_of((start + i) % (1 << LW)), last: (i == count - 1)});
      end
      size_q.push_back(sz);
      @(negedge clk);
      req_val = 1'b1;
      req_start_idx = LW'(start);
      req_count = 16'(count);
      #4 chk("req_rdy_accept", req_rdy, 1'b1);
      @(negedge clk);
      req_val = 1'b0;
   endtask

   task automatic run_req(input int start, input int count, input int l, input bit s,
                          input logic [31:0] sz);
      bit done;
      setup_req(start, count, l, s, sz);
      done = 1'b0;
      for (int n = 0; n < 300 && !done; n++) begin
         @(negedge clk);
         done = (beat_q.size() == 0) && (addr_q.size() == 0) && (size_q.size() == 0);
      end
      chk("complete", done, 1'b1);
      repeat (2) @(negedge clk);
      #4;
      chk("idle_req_rdy", req_rdy, 1'b1);
      chk("reads_issued", reads_seen, count);
      chk("beats_out", beats_seen, count);
      chk("outstanding_le2", (max_out <= 2), 1'b1);
      if (l == 1 && !s && count > 0) chk("back_to_back", last_beat_cyc - first_beat_cyc, count - 1);
   endtask

   vec_t vecs[6];

   initial begin
      bit got2;
      vecs[0] = '{start: 5,    count: 3, lat: 1, stall: 1'b0, size: 32'd192};
      vecs[1] = '{start: 1022, count: 4, lat: 1, stall: 1'b0, size: 32'd256};
      vecs[2] = '{start: 7,    count: 0, lat: 1, stall: 1'b0, size: 32'd0};
      vecs[3] = '{start: 10,   count: 6, lat: 3, stall: 1'b1, size: 32'd384};
      vecs[4] = '{start: 100,  count: 5, lat: 2, stall: 1'b0, size: 32'd320};
      vecs[5] = '{start: 1023, count: 2, lat: 4, stall: 1'b1, size: 32'd128};

      repeat (3) @(negedge clk);
      #4;
      chk("rst_req_rdy", req_rdy, 1'b0);
      chk("rst_size_val", size_val, 1'b0);
      chk("rst_data_val", data_val, 1'b0);
      chk("rst_data_last", data_last, 1'b0);
      chk("rst_rd_val", log_rd_req_val, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #4;
      chk("post_rst_req_rdy", req_rdy, 1'b1);
      chk("post_rst_size_bytes", size_bytes, 32'd0);
      chk("post_rst_addr", log_rd_req_addr, 10'd0);

      // A stray RAM response while idle must not produce a beat.
      @(posedge clk) spur = 1'b1;
      @(posedge clk) spur = 1'b0;
      @(negedge clk);
      #4 chk("stray_resp_ignored", data_val, 1'b0);

      for (int v = 0; v < 6; v++)
         run_req(vecs[v].start, vecs[v].count, vecs[v].lat, vecs[v].stall, vecs[v].size);

      // Reset in the middle of an 8-entry stream, after two beats.
      setup_req(20, 8, 1, 1'b0, 32'd512);
      got2 = 1'b0;
      for (int n = 0; n < 100 && !got2; n++) begin
         @(negedge clk);
         got2 = (beats_seen >= 2);
      end
      chk("two_beats_before_rst", got2, 1'b1);
      rst = 1'b1;
      beat_q.delete();
      addr_q.delete();
      size_q.delete();
      ram_q.delete();
      #4;
      chk("mid_rst_data_val", data_val, 1'b0);
      chk("mid_rst_rd_val", log_rd_req_val, 1'b0);
      chk("mid_rst_size_val", size_val, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #4;
      chk("after_rst_data_val", data_val, 1'b0);
      chk("after_rst_rd_val", log_rd_req_val, 1'b0);
      chk("after_rst_last", data_last, 1'b0);
      chk("after_rst_idle", req_rdy, 1'b1);
      run_req(0, 1, 1, 1'b0, 32'd64);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
